// File: rtl/control_multiciclo_pkg.sv
// ---------------------------------------------------------------------------
// control_multiciclo_pkg
// Shared definitions for the multicycle control unit: state encoding,
// supported opcodes, ALU operation codes, ALU operand / PC source selects
// and the bundled control-word structure exchanged between the FSM top
// and its output decoder.
// ---------------------------------------------------------------------------
package control_multiciclo_pkg;

  // State encoding is also exported on the debug 'state' port, so the
  // numeric values are fixed here rather than left to the tool.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9
  } state_t;

  // Supported instruction opcodes
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  // ALU operand B selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // Complete control word produced by the decoder for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the four opcodes this control unit knows how to sequence
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/control_multiciclo_decode.sv
// ---------------------------------------------------------------------------
// control_multiciclo_decode
// Pure combinational decode of the registered FSM state into the datapath
// control word. Only FETCH looks at mem_ready, so the IR and PC are written
// exactly in the cycle the instruction word arrives from memory.
//
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory handshake (access completes when 1)
//   ctrl      out  control word for this cycle
// ---------------------------------------------------------------------------
module control_multiciclo_decode
  import control_multiciclo_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Every field starts at zero, so each state only lists what it asserts.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        // Precompute branch target while the register file is read
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      ST_BRANCH: begin
        // Compare operands; PC takes the target held in ALUOut if Zero
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// ---------------------------------------------------------------------------
// control_multiciclo
// Multicycle MIPS-style control unit supporting R-type, LW, SW and BEQ.
// The FSM leaves IDLE once 'run' is seen and then loops through
// instructions forever; only reset brings it back to IDLE.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   run               start request, looked at only in IDLE
//   OpCode            opcode from the instruction register
//   Zero              ALU zero flag (gates PCWriteCond in the datapath)
//   mem_ready         memory handshake
//   PCWrite..ALUSrcA  single-bit datapath controls
//   ALUSrcB, ALUOp    ALU operand / operation selects
//   PCSource          PC input select
//   illegal_op        one-cycle pulse in DECODE on an unknown opcode
//   state             current state encoding (debug)
// ---------------------------------------------------------------------------
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] OpCode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemToWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Zero is applied to PCWriteCond inside the datapath, not here; it is
  // kept on the port list so the control/datapath boundary stays complete.
  logic unused_zero;
  assign unused_zero = Zero;

  // State register; reset aborts any instruction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Memory states hold until the handshake completes;
  // an unknown opcode in DECODE simply restarts with a fresh fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (run) state_d = ST_FETCH;
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (OpCode == OP_R)                          state_d = ST_EXEC_R;
        else if ((OpCode == OP_LW) || (OpCode == OP_SW)) state_d = ST_MEM_ADDR;
        else if (OpCode == OP_BEQ)                   state_d = ST_BRANCH;
        else                                         state_d = ST_FETCH;
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (OpCode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_WB_MEM:   state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      default:     state_d = ST_IDLE;
    endcase
  end

  control_multiciclo_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemToWrite  = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

  // DECODE lasts exactly one cycle, so this is naturally a single pulse.
  assign illegal_op = (state_q == ST_DECODE) && !is_supported_op(OpCode);

  assign state = state_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_control_multiciclo
// Self-checking bench for the multicycle control unit. A path-based model
// (list of states visited per opcode, advanced each cycle unless a memory
// access is still pending) predicts state and control outputs; a compare
// process checks them every negative edge. Directed sequences pin the
// instruction latencies, wait-state stretching, the illegal-op pulse and
// asynchronous reset; a randomized phase then exercises everything.
// ---------------------------------------------------------------------------
module tb_control_multiciclo;
  import control_multiciclo_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [5:0] OpCode = 6'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic [3:0] state;

  int checks = 0;
  int passed = 0;

  control_multiciclo dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .OpCode      (OpCode),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemToWrite  (MemToWrite),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs in a fixed order
  logic [17:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite,
                    RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, illegal_op};

  // Generic comparison with pass/fail bookkeeping
  task automatic checkOutput(input string name, input logic [17:0] act,
                             input logic [17:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each opcode visits a fixed list of states starting at FETCH; the
  // machine walks the list and wraps back to FETCH at its end.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      OP_R:    return 4;
      OP_LW:   return 5;
      OP_SW:   return 4;
      OP_BEQ:  return 3;
      default: return 2;
    endcase
  endfunction

  function automatic state_t path_state(input logic [5:0] op, input int pos);
    state_t r_path [4] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R};
    state_t lw_path[5] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_WB_MEM};
    state_t sw_path[4] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR};
    state_t bq_path[3] = '{ST_FETCH, ST_DECODE, ST_BRANCH};
    state_t il_path[2] = '{ST_FETCH, ST_DECODE};
    case (op)
      OP_R:    return r_path[pos];
      OP_LW:   return lw_path[pos];
      OP_SW:   return sw_path[pos];
      OP_BEQ:  return bq_path[pos];
      default: return il_path[pos];
    endcase
  endfunction

  bit m_idle = 1'b1;
  int m_pos  = 0;

  function automatic state_t model_state();
    if (m_idle) return ST_IDLE;
    return path_state(OpCode, m_pos);
  endfunction

  // Expected control word from the per-state output table
  function automatic logic [17:0] exp_vec(input state_t s, input logic mr,
                                          input logic [5:0] op);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic rdst = 0, m2r = 0, rw = 0, srca = 0, ill = 0;
    logic [1:0] srcb = 2'b00;
    logic [2:0] aop = 3'b000;
    logic [1:0] pcs = 2'b00;
    case (s)
      ST_FETCH:    begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE:   begin
        srcb = 2'b11;
        ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100);
      end
      ST_EXEC_R:   begin srca = 1; aop = 3'b010; end
      ST_WB_R:     begin rdst = 1; rw = 1; end
      ST_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      ST_MEM_RD:   begin mrd = 1; iord = 1; end
      ST_MEM_WR:   begin mwr = 1; iord = 1; end
      ST_WB_MEM:   begin m2r = 1; rw = 1; end
      ST_BRANCH:   begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      default:     ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, ill};
  endfunction

  // Model advance: memory-waiting positions hold while mem_ready is low
  always @(posedge clk or posedge reset) begin
    state_t cur;
    if (reset) begin
      m_idle = 1'b1;
      m_pos  = 0;
    end else if (m_idle) begin
      if (run) begin
        m_idle = 1'b0;
        m_pos  = 0;
      end
    end else begin
      cur = path_state(OpCode, m_pos);
      if (!((cur == ST_FETCH || cur == ST_MEM_RD || cur == ST_MEM_WR) && !mem_ready))
        m_pos = (m_pos + 1) % path_len(OpCode);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    checkOutput("state", 18'(state), 18'(model_state()));
    checkOutput("ctrl", dut_vec, exp_vec(model_state(), mem_ready, OpCode));
    checkOutput("rw_memwr_excl", 18'(RegWrite & MemToWrite), 18'd0);
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic mr);
    run = r;
    OpCode = op;
    mem_ready = mr;
    Zero = 1'($urandom_range(0, 1));
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction starting in FETCH (at posedge+2); inserts 'waits'
  // not-ready cycles into the data memory access. Returns cycles until
  // FETCH is re-entered (-1 on timeout), illegal_op pulses and MEM_RD cycles.
  task automatic runInstr(input logic [5:0] op, input int waits, output int cycles,
                          output int pulses, output int rd_cycles);
    int left = waits;
    cycles = 0;
    pulses = 0;
    rd_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      run = 1'b0;
      OpCode = op;
      Zero = 1'($urandom_range(0, 1));
      mem_ready = ((state == ST_MEM_RD || state == ST_MEM_WR) && left > 0) ? 1'b0 : 1'b1;
      if (state == ST_MEM_RD) rd_cycles++;
      if (!mem_ready) left--;
      @(negedge clk);
      if (illegal_op) pulses++;
      @(posedge clk);
      #2;
      cycles++;
      if (state == ST_FETCH) return;
    end
    cycles = -1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return OP_R;
      1:       return OP_LW;
      2:       return OP_SW;
      3:       return OP_BEQ;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    int cyc, pul, rdc;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", 18'(state), 18'(ST_IDLE));
    checkOutput("reset_outs", dut_vec, 18'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // IDLE holds without run, then run starts fetching
    repeat (3) applyStimulus(1'b0, 6'd0, 1'b1);
    checkOutput("idle_hold", 18'(state), 18'(ST_IDLE));
    applyStimulus(1'b1, 6'd0, 1'b1);
    checkOutput("run_to_fetch", 18'(state), 18'(ST_FETCH));

    // Instruction latencies with memory always ready
    runInstr(OP_R, 0, cyc, pul, rdc);
    checkOutput("lat_r", 18'(cyc), 18'd4);
    runInstr(OP_LW, 0, cyc, pul, rdc);
    checkOutput("lat_lw", 18'(cyc), 18'd5);
    runInstr(OP_SW, 0, cyc, pul, rdc);
    checkOutput("lat_sw", 18'(cyc), 18'd4);
    runInstr(OP_BEQ, 0, cyc, pul, rdc);
    checkOutput("lat_beq", 18'(cyc), 18'd3);

    // LW with two wait cycles in MEM_RD
    runInstr(OP_LW, 2, cyc, pul, rdc);
    checkOutput("lat_lw_wait", 18'(cyc), 18'd7);
    checkOutput("memrd_cycles", 18'(rdc), 18'd3);

    // SW with one wait cycle
    runInstr(OP_SW, 1, cyc, pul, rdc);
    checkOutput("lat_sw_wait", 18'(cyc), 18'd5);

    // Unsupported opcode: single pulse, back to FETCH after DECODE
    runInstr(6'b111111, 0, cyc, pul, rdc);
    checkOutput("lat_illegal", 18'(cyc), 18'd2);
    checkOutput("illegal_pulses", 18'(pul), 18'd1);

    // Asynchronous reset in the middle of MEM_RD
    OpCode = OP_LW;
    for (int k = 0; k < 10; k++) begin
      if (state == ST_MEM_RD) break;
      mem_ready = 1'b1;
      @(posedge clk);
      #2;
    end
    mem_ready = 1'b0;
    checkOutput("reach_memrd", 18'(state), 18'(ST_MEM_RD));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_state", 18'(state), 18'(ST_IDLE));
    checkOutput("async_rst_outs", dut_vec, 18'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, OP_R, 1'b1);
    checkOutput("rst_then_fetch", 18'(state), 18'(ST_FETCH));

    // Randomized phase; opcode only changes when a new fetch begins
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      run = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      Zero = 1'($urandom_range(0, 1));
      if (m_idle || m_pos == 0) OpCode = pick_op();
      @(posedge clk);
      #2;
    end

    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  enables leaving IDLE; sampled only in IDLE.
REQ-005 OpCode  input  6  instruction opcode from instruction register, valid from DECODE onward.
REQ-006 Zero  input  1  ALU zero flag, used only in BRANCH.
REQ-007 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite  output  1 each  PC/memory/IR controls.
REQ-009 RegDst, MemToReg, RegWrite, ALUSrcA  output  1 each  register-file and ALU-A controls.
REQ-010 ALUSrcB  output  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-011 ALUOp  output  3  000 add, 001 sub, 010 R-type funct-decoded; others unused.
REQ-012 PCSource  output  2  00 ALU result, 01 ALUOut register.
REQ-013 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-014 state  output  4  current state encoding, for debug and bench.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXEC_R, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH.
REQ-016 IDLE: all outputs 0; next FETCH if run=1, else IDLE.
REQ-017 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, go DECODE when 1.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; next by OpCode: 000000->EXEC_R, 100011 or 101011->MEM_ADDR, 000100->BRANCH, other->FETCH with illegal_op=1 this cycle.
REQ-019 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010; next WB_R.
REQ-020 WB_R: RegDst=1, MemToReg=0, RegWrite=1; next FETCH.
REQ-021 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEM_RD if OpCode=100011, else MEM_WR.
REQ-022 MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1, then WB_MEM.
REQ-023 MEM_WR: MemToWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-024 WB_MEM: RegDst=0, MemToReg=1, RegWrite=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01; next FETCH.
REQ-026 Any output not listed for a state SHALL be 0 in that state.
REQ-027 Outputs SHALL be a combinational decode of the registered state (plus mem_ready in FETCH).
REQ-028 Latency with mem_ready=1 throughout: R 4, LW 5, SW 4, BEQ 3 cycles from FETCH entry to next FETCH entry; each mem_ready=0 cycle adds one.
REQ-029 RegWrite and MemToWrite SHALL never both be 1 in the same cycle.
REQ-030 run is ignored outside IDLE; the machine never returns to IDLE except by reset.

Reset
REQ-031 reset=1 SHALL force state=IDLE immediately, independent of clk, aborting any instruction mid-sequence.
REQ-032 During and after reset all outputs SHALL be 0 until the FSM leaves IDLE.

Structure
REQ-033 A shared package SHALL hold state encodings, opcode constants (R, LW, SW, BEQ) and ALUOp codes.
REQ-034 One sub-module, control_multiciclo_decode (state, mem_ready -> outputs), is natural; next-state logic stays in the top.

Verification
REQ-035 reset mid-MEM_RD -> state=IDLE same cycle, all outputs 0; run=1 -> FETCH next edge.
REQ-036 OpCode=000000, mem_ready=1 -> FETCH, DECODE, EXEC_R(ALUOp=010), WB_R(RegWrite=1, RegDst=1), FETCH.
REQ-037 OpCode=100011, mem_ready 0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, then WB_MEM with MemToReg=1.
REQ-038 OpCode=101011 -> MEM_WR with MemToWrite=1, RegWrite=0 throughout; returns to FETCH.
REQ-039 OpCode=000100 -> BRANCH with PCWriteCond=1, ALUOp=001, PCSource=01; 3-cycle loop.
REQ-040 OpCode=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH.
